// File: rtl/keymap_learn_ctrl_pkg.sv
// Shared types and helpers for the key-binding learn controller.
// Key-width constants, FSM state and error encodings, one-hot test.
package keymap_learn_ctrl_pkg;

    localparam int unsigned NOTE_KEY_BITS   = 7;
    localparam int unsigned LENGTH_KEY_BITS = 4;

    // Widest key vector onehot_valid accepts; callers zero-extend.
    localparam int unsigned MaxKeyW = 32;

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StCapture,
        StRelease,
        StCommit
    } state_e;

    typedef enum logic [1:0] {
        ErrCancel  = 2'd0,
        ErrBadSlot = 2'd1,
        ErrTimeout = 2'd2
    } err_code_e;

    typedef enum logic {
        DetZero,
        DetOneHot
    } det_mode_e;

    function automatic logic onehot_valid(input logic [MaxKeyW-1:0] v);
        return (v != '0) && ((v & (v - MaxKeyW'(1))) == '0);
    endfunction

endpackage

// File: rtl/keymap_learn_ctrl_if.sv
// Write port bundle towards the key-binding RAM: note table (0) and length table (1).
interface keymap_learn_ctrl_if #(
    parameter int unsigned NOTE_W = 7,
    parameter int unsigned LEN_W  = 4
);
    logic              rw0;
    logic [NOTE_W-1:0] addr0;
    logic [NOTE_W-1:0] in0;
    logic              rw1;
    logic [LEN_W-1:0]  addr1;
    logic [LEN_W-1:0]  in1;

    modport master (
        output rw0, addr0, in0,
        output rw1, addr1, in1
    );

    modport slave (
        input rw0, addr0, in0,
        input rw1, addr1, in1
    );
endinterface

// File: rtl/keymap_learn_ctrl_key_stable_det.sv
// Debounce detector: pulses 'stable' once the key vector has matched the selected
// pattern (all-zero or single-hot) with the same value for DEB_CYC consecutive cycles.
module keymap_learn_ctrl_key_stable_det
    import keymap_learn_ctrl_pkg::*;
#(
    parameter int unsigned W       = 7,
    parameter int unsigned DEB_CYC = 20000,
    parameter int unsigned CNT_W   = 16
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      clear,
    input  logic [W-1:0] vec,
    input  det_mode_e mode,
    output logic      stable
);

    logic [W-1:0]     prev_q;
    logic [CNT_W-1:0] run_q;
    logic [CNT_W-1:0] run_d;
    logic             qual;

    // run_d counts the current cycle; run_q == 0 means prev_q is not a valid match.
    always_comb begin
        qual  = (mode == DetZero) ? (vec == '0) : onehot_valid(MaxKeyW'(vec));
        run_d = '0;
        if (qual) begin
            if (run_q != '0 && vec == prev_q) begin
                run_d = (run_q == '1) ? run_q : run_q + CNT_W'(1);
            end else begin
                run_d = CNT_W'(1);
            end
        end
        stable = qual && (run_d >= CNT_W'(DEB_CYC));
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            run_q  <= '0;
            prev_q <= '0;
        end else begin
            run_q  <= run_d;
            prev_q <= vec;
        end
    end

endmodule

// File: rtl/keymap_learn_ctrl.sv
// Learn controller for the key-binding RAM: arm, capture one debounced key, wait for
// release, then issue a single write. Optional abort timeout: KEYMAP_LEARN_TIMEOUT_EN.
module keymap_learn_ctrl
    import keymap_learn_ctrl_pkg::*;
#(
    parameter int unsigned NOTE_W  = NOTE_KEY_BITS,
    parameter int unsigned LEN_W   = LENGTH_KEY_BITS,
    parameter int unsigned DEB_CYC = 20000,
    parameter int unsigned TMO_CYC = 50000000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      learn_start,
    input  logic                      learn_sel,
    input  logic [$clog2(NOTE_W)-1:0] slot,
    input  logic                      cancel,
    input  logic [NOTE_W-1:0]         note_keys,
    input  logic [LEN_W-1:0]          len_keys,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [1:0]                err_code,
    keymap_learn_ctrl_if.master       ram
);

    localparam int unsigned SlotW  = $clog2(NOTE_W);
    localparam int unsigned MaxCyc = (DEB_CYC > TMO_CYC) ? DEB_CYC : TMO_CYC;
    localparam int unsigned CntW   = $clog2(MaxCyc) + 1;

    state_e            state_q, state_d;
    logic              sel_q, sel_d;
    logic [SlotW-1:0]  slot_q, slot_d;
    logic [NOTE_W-1:0] cap_q, cap_d;
    logic              err_d;
    err_code_e         err_code_q, err_code_d;

    logic              busy_q, done_q, err_q;
    logic              rw0_q, rw1_q;
    logic [NOTE_W-1:0] addr0_q, in0_q;
    logic [LEN_W-1:0]  addr1_q, in1_q;
    logic              rw0_d, rw1_d;

    logic [NOTE_W-1:0] key_vec;
    logic              slot_ok;
    det_mode_e         det_mode;
    logic              det_clear;
    logic              det_stable;
    logic              tmo_hit;

    assign key_vec   = sel_q ? NOTE_W'(len_keys) : note_keys;
    assign slot_ok   = learn_sel ? (32'(slot) < LEN_W) : (32'(slot) < NOTE_W);
    // Restart debouncing (and the timeout) on every state change.
    assign det_clear = (state_d != state_q);

    keymap_learn_ctrl_key_stable_det #(
        .W       (NOTE_W),
        .DEB_CYC (DEB_CYC),
        .CNT_W   (CntW)
    ) u_key_stable_det (
        .clk    (clk),
        .rst    (rst),
        .clear  (det_clear),
        .vec    (key_vec),
        .mode   (det_mode),
        .stable (det_stable)
    );

`ifdef KEYMAP_LEARN_TIMEOUT_EN
    logic [CntW-1:0] tmo_q;

    assign tmo_hit = (tmo_q >= CntW'(TMO_CYC - 1)) &&
                     (state_q == StArm || state_q == StCapture);

    always_ff @(posedge clk) begin
        if (rst || det_clear) begin
            tmo_q <= '0;
        end else if (tmo_q != '1) begin
            tmo_q <= tmo_q + CntW'(1);
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        slot_d     = slot_q;
        cap_d      = cap_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        det_mode   = DetZero;

        unique case (state_q)
            StIdle: begin
                if (learn_start) begin
                    if (slot_ok) begin
                        sel_d   = learn_sel;
                        slot_d  = slot;
                        state_d = StArm;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ErrBadSlot;
                    end
                end
            end
            StArm: begin
                if (det_stable) state_d = StCapture;
            end
            StCapture: begin
                det_mode = DetOneHot;
                if (det_stable) begin
                    cap_d   = key_vec;
                    state_d = StRelease;
                end
            end
            StRelease: begin
                if (det_stable) state_d = StCommit;
            end
            StCommit: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // COMMIT is excluded, so a cancel landing on the write cycle is ignored.
        if (cancel && (state_q inside {StArm, StCapture, StRelease})) begin
            state_d    = StIdle;
            err_d      = 1'b1;
            err_code_d = ErrCancel;
        end else if (tmo_hit) begin
            state_d    = StIdle;
            err_d      = 1'b1;
            err_code_d = ErrTimeout;
        end
    end

    assign rw0_d = (state_d == StCommit) && !sel_q;
    assign rw1_d = (state_d == StCommit) && sel_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            sel_q      <= 1'b0;
            slot_q     <= '0;
            cap_q      <= '0;
            err_code_q <= ErrCancel;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rw0_q      <= 1'b0;
            rw1_q      <= 1'b0;
            addr0_q    <= '0;
            in0_q      <= '0;
            addr1_q    <= '0;
            in1_q      <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            slot_q     <= slot_d;
            cap_q      <= cap_d;
            err_code_q <= err_code_d;
            busy_q     <= state_d inside {StArm, StCapture, StRelease};
            done_q     <= (state_d == StCommit);
            err_q      <= err_d;
            rw0_q      <= rw0_d;
            rw1_q      <= rw1_d;
            // Address and data hold between writes.
            if (rw0_d) begin
                addr0_q <= NOTE_W'(1) << slot_q;
                in0_q   <= cap_q;
            end
            if (rw1_d) begin
                addr1_q <= LEN_W'(1) << slot_q;
                in1_q   <= cap_q[LEN_W-1:0];
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign ram.rw0   = rw0_q;
    assign ram.addr0 = addr0_q;
    assign ram.in0   = in0_q;
    assign ram.rw1   = rw1_q;
    assign ram.addr1 = addr1_q;
    assign ram.in1   = in1_q;

endmodule

// File: tb/tb_keymap_learn_ctrl.sv
// Bench for keymap_learn_ctrl with DEB_CYC=4, TMO_CYC=32; expected writes are queued
// at stimulus time and checked when the RAM strobe fires.
module tb_keymap_learn_ctrl;

    localparam int unsigned NOTE_W = 7;
    localparam int unsigned LEN_W  = 4;
    localparam int unsigned DEB    = 4;
    localparam int unsigned TMO    = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              learn_start = 1'b0;
    logic              learn_sel = 1'b0;
    logic [2:0]        slot = '0;
    logic              cancel = 1'b0;
    logic [NOTE_W-1:0] note_keys = '0;
    logic [LEN_W-1:0]  len_keys = '0;
    logic              busy, done, err;
    logic [1:0]        err_code;

    int checks = 0;
    int passes = 0;
    int write_cnt = 0;

    typedef struct packed {
        logic       sel;
        logic [6:0] addr;
        logic [6:0] data;
    } exp_t;
    exp_t sb[$];

    keymap_learn_ctrl_if #(.NOTE_W(NOTE_W), .LEN_W(LEN_W)) ram ();

    keymap_learn_ctrl #(
        .NOTE_W  (NOTE_W),
        .LEN_W   (LEN_W),
        .DEB_CYC (DEB),
        .TMO_CYC (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .learn_start (learn_start),
        .learn_sel   (learn_sel),
        .slot        (slot),
        .cancel      (cancel),
        .note_keys   (note_keys),
        .len_keys    (len_keys),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .err_code    (err_code),
        .ram         (ram)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ram.rw0 === 1'b1 || ram.rw1 === 1'b1) write_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_learn(input logic s, input logic [2:0] sl);
        learn_sel   = s;
        slot        = sl;
        learn_start = 1'b1;
        step(1);
        learn_start = 1'b0;
    endtask

    // Waits for a RAM write, pops the expected entry and checks the write cycle.
    task automatic wait_commit(input string tag, input logic cancel_on_commit);
        int n;
        exp_t e;
        logic [6:0] a, d;
        logic [1:0] want_rw;
        n = 0;
        while (!(ram.rw0 === 1'b1 || ram.rw1 === 1'b1) && n < 200) begin
            step(1);
            n++;
        end
        checks++;
        if (!(ram.rw0 === 1'b1 || ram.rw1 === 1'b1)) begin
            $display("FAIL %s_write: got no write in 200 cycles, want one", tag);
            if (sb.size() != 0) void'(sb.pop_front());
            return;
        end
        passes++;
        checks++;
        if (sb.size() == 0) begin
            $display("FAIL %s_sb: got unexpected write, want none", tag);
            return;
        end
        passes++;
        e       = sb.pop_front();
        want_rw = e.sel ? 2'b10 : 2'b01;
        a       = e.sel ? {3'b000, ram.addr1} : ram.addr0;
        d       = e.sel ? {3'b000, ram.in1} : ram.in0;
        checks++;
        if ({ram.rw1, ram.rw0} !== want_rw)
            $display("FAIL %s_strobe: got %b want %b", tag, {ram.rw1, ram.rw0}, want_rw);
        else passes++;
        checks++;
        if (a !== e.addr) $display("FAIL %s_addr: got %b want %b", tag, a, e.addr);
        else passes++;
        checks++;
        if (d !== e.data) $display("FAIL %s_data: got %b want %b", tag, d, e.data);
        else passes++;
        checks++;
        if ({done, busy} !== 2'b10)
            $display("FAIL %s_done_busy: got %b want 10", tag, {done, busy});
        else passes++;
        if (cancel_on_commit) cancel = 1'b1;
        step(1);
        cancel = 1'b0;
        checks++;
        if ({ram.rw1, ram.rw0, done} !== 3'b000)
            $display("FAIL %s_pulse_end: got %b want 000", tag, {ram.rw1, ram.rw0, done});
        else passes++;
        if (cancel_on_commit) begin
            checks++;
            if (err !== 1'b0) $display("FAIL %s_cancel_ignored: got err=%b want 0", tag, err);
            else passes++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(2);
        checks++;
        if ({busy, done, err, err_code, ram.rw0, ram.rw1, ram.addr0, ram.in0, ram.addr1,
             ram.in1} !== '0)
            $display("FAIL reset_outputs: got busy=%b done=%b err=%b code=%0d rw=%b%b",
                     busy, done, err, err_code, ram.rw1, ram.rw0);
        else passes++;
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_note_learn();
        sb.push_back('{sel: 1'b0, addr: 7'b0000100, data: 7'b0010000});
        start_learn(1'b0, 3'd2);
        checks++;
        if (busy !== 1'b1) $display("FAIL note_busy: got %b want 1", busy);
        else passes++;
        note_keys = '0;
        step(DEB);
        note_keys = 7'b0010000;
        step(DEB);
        note_keys = '0;
        wait_commit("note", 1'b0);
    endtask

    task automatic test_bad_slot();
        int wc;
        wc = write_cnt;
        start_learn(1'b1, 3'd5);
        checks++;
        if ({err, err_code, busy} !== 4'b1010)
            $display("FAIL badslot_len: got err=%b code=%0d busy=%b want 1,1,0",
                     err, err_code, busy);
        else passes++;
        step(1);
        checks++;
        if ({err, err_code} !== 3'b001)
            $display("FAIL badslot_pulse: got err=%b code=%0d want 0,1", err, err_code);
        else passes++;
        start_learn(1'b0, 3'd7);
        checks++;
        if ({err, err_code, busy} !== 4'b1010)
            $display("FAIL badslot_note: got err=%b code=%0d busy=%b want 1,1,0",
                     err, err_code, busy);
        else passes++;
        cancel = 1'b1;
        step(1);
        cancel = 1'b0;
        checks++;
        if ({err, err_code, busy} !== 4'b0010)
            $display("FAIL idle_cancel: got err=%b code=%0d busy=%b want 0,1,0",
                     err, err_code, busy);
        else passes++;
        step(4);
        checks++;
        if (write_cnt !== wc) $display("FAIL badslot_nowrite: got %0d writes want %0d",
                                       write_cnt, wc);
        else passes++;
    endtask

    task automatic test_cancel_release();
        int wc;
        wc = write_cnt;
        start_learn(1'b1, 3'd3);
        len_keys = '0;
        step(DEB);
        len_keys = 4'b0100;
        step(DEB + 2);
        cancel = 1'b1;
        step(1);
        cancel = 1'b0;
        checks++;
        if ({err, err_code, busy} !== 4'b1000)
            $display("FAIL cancel_err: got err=%b code=%0d busy=%b want 1,0,0",
                     err, err_code, busy);
        else passes++;
        step(1);
        checks++;
        if (err !== 1'b0) $display("FAIL cancel_pulse: got %b want 0", err);
        else passes++;
        step(6);
        checks++;
        if (write_cnt !== wc) $display("FAIL cancel_nowrite: got %0d writes want %0d",
                                       write_cnt, wc);
        else passes++;
        // Key still held at restart; ARM must wait for it to go away.
        sb.push_back('{sel: 1'b1, addr: 7'b0001000, data: 7'b0000010});
        start_learn(1'b1, 3'd3);
        step(3);
        len_keys = '0;
        step(DEB + 1);
        len_keys = 4'b0010;
        step(DEB);
        len_keys = '0;
        wait_commit("after_cancel", 1'b0);
    endtask

    task automatic test_multi_key();
        int wc;
        sb.push_back('{sel: 1'b0, addr: 7'b0100000, data: 7'b0000001});
        start_learn(1'b0, 3'd5);
        note_keys = '0;
        step(DEB);
        wc = write_cnt;
        note_keys = 7'b0010010;
        step(10);
        checks++;
        if ({write_cnt == wc, busy} !== 2'b11)
            $display("FAIL multikey_hold: got writes=%0d busy=%b want %0d,1", write_cnt,
                     busy, wc);
        else passes++;
        note_keys = 7'b0000001;
        step(DEB);
        note_keys = '0;
        wait_commit("multikey", 1'b0);
    endtask

    task automatic test_held_key();
        int wc;
        sb.push_back('{sel: 1'b0, addr: 7'b0000010, data: 7'b0000100});
        note_keys = 7'b0000001;
        wc = write_cnt;
        start_learn(1'b0, 3'd1);
        step(10);
        checks++;
        if ({write_cnt == wc, busy} !== 2'b11)
            $display("FAIL held_wait: got writes=%0d busy=%b want %0d,1", write_cnt, busy, wc);
        else passes++;
        note_keys = '0;
        step(DEB + 1);
        note_keys = 7'b0000100;
        step(DEB);
        note_keys = '0;
        wait_commit("held", 1'b0);
    endtask

    task automatic test_back_to_back();
        // Second start while busy must not retarget; cancel on the write cycle is ignored.
        sb.push_back('{sel: 1'b0, addr: 7'b0001000, data: 7'b1000000});
        start_learn(1'b0, 3'd3);
        step(2);
        start_learn(1'b1, 3'd1);
        note_keys = '0;
        step(DEB);
        note_keys = 7'b1000000;
        step(DEB);
        note_keys = '0;
        wait_commit("busy_start", 1'b1);
        checks++;
        if (busy !== 1'b0) $display("FAIL busy_start_idle: got busy=%b want 0", busy);
        else passes++;
    endtask

    task automatic test_reset_mid_learn();
        int wc;
        wc = write_cnt;
        start_learn(1'b0, 3'd4);
        note_keys = '0;
        step(DEB + 1);
        note_keys = 7'b0000010;
        step(DEB + 1);
        rst = 1'b1;
        step(1);
        checks++;
        if ({busy, done, err, err_code, ram.rw0, ram.rw1, ram.addr0, ram.in0, ram.addr1,
             ram.in1} !== '0)
            $display("FAIL midreset_outputs: got busy=%b done=%b err=%b addr0=%b in0=%b",
                     busy, done, err, ram.addr0, ram.in0);
        else passes++;
        rst = 1'b0;
        note_keys = '0;
        step(20);
        checks++;
        if ({write_cnt == wc, busy} !== 2'b10)
            $display("FAIL midreset_idle: got writes=%0d busy=%b want %0d,0", write_cnt,
                     busy, wc);
        else passes++;
    endtask

    task automatic test_timeout();
        int wc;
        wc = write_cnt;
        note_keys = '0;
        start_learn(1'b0, 3'd0);
`ifdef KEYMAP_LEARN_TIMEOUT_EN
        begin
            int n;
            n = 0;
            while (err !== 1'b1 && n < 100) begin
                step(1);
                n++;
            end
            checks++;
            if ({err, err_code, busy} !== 4'b1100)
                $display("FAIL timeout_err: got err=%b code=%0d busy=%b want 1,2,0",
                         err, err_code, busy);
            else passes++;
        end
`else
        step(100);
        checks++;
        if (busy !== 1'b1) $display("FAIL no_timeout_busy: got %b want 1", busy);
        else passes++;
        cancel = 1'b1;
        step(1);
        cancel = 1'b0;
        checks++;
        if ({err, err_code, busy} !== 4'b1000)
            $display("FAIL no_timeout_cancel: got err=%b code=%0d busy=%b want 1,0,0",
                     err, err_code, busy);
        else passes++;
`endif
        step(2);
        checks++;
        if (write_cnt !== wc) $display("FAIL timeout_nowrite: got %0d writes want %0d",
                                       write_cnt, wc);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_note_learn();
        test_bad_slot();
        test_cancel_release();
        test_multi_key();
        test_held_key();
        test_back_to_back();
        test_reset_mid_learn();
        test_timeout();
        checks++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
